dffram_stream_reader: RTL and testbench
=======================================

Name: dffram_stream_reader

Overview:
- Read-side controller for the dual-port DFF RAM: drives the RAM's read address (adr_r) and consumes its registered read data (dat_o2).
- Streams a run of consecutive words out on a valid/ready stream to the systolic array datapath; last beat is flagged.
- A 2-entry output buffer absorbs the RAM's 1-cycle read latency under backpressure.
- One command in flight at a time, with start/busy/done handshake.

Parameters:
- DWIDTH, 24, word width; equals the RAM's DWIDTH.
- AWIDTH, 6, address width; RAM depth is 2**AWIDTH.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- base_adr  in  AWIDTH  first read address; captured when start is accepted.
- len  in  AWIDTH+1  number of words to stream; captured when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle completion pulse.
- mem_adr_r  out  AWIDTH  registered read address to the RAM adr_r.
- mem_dat_i  in  DWIDTH  RAM dat_o2; holds r[adr] one cycle after adr is presented.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DWIDTH  stream word.
- m_last  out  1  high with the final word of the command.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE; output buffer flushed; in-flight read discarded.
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_adr_r=0.
  - Takes effect mid-command with no partial beats afterwards; a pending start in the same cycle is ignored.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1:
  - Captures base_adr and len; remaining issues = len; next read address = base_adr.
  - len=0: go to DONE; no beats, no reads.
  - Otherwise: go to ISSUE.
- ISSUE:
  - A read is issued in a cycle when mem_adr_r holds the next address and the issue condition holds: occupancy + inflight - pop < 2.
    - occupancy: buffer entries (0..2).
    - inflight: 1 if a read was issued last cycle.
    - pop: m_valid & m_ready this cycle.
  - Issued reads capture mem_dat_i into the buffer on the following posedge.
  - Address increments mod 2**AWIDTH: base 62, AWIDTH 6 -> 62, 63, 0, 1.
  - len greater than 2**AWIDTH rereads wrapped addresses.
  - After the last issue, go to DRAIN.
- DRAIN: wait until the buffer is empty and nothing is in flight, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in ISSUE, DRAIN and DONE's preceding cycles; busy=0 in IDLE and in the done cycle.
- Latency: start high in cycle 0 -> mem_adr_r=base in cycle 1 -> data on mem_dat_i in cycle 2 -> m_valid=1 with word 0 in cycle 3.
- Throughput: with m_ready held high, one word per cycle, no bubbles, until the final beat.
- Stream rules:
  - Once asserted, m_valid stays high and m_data/m_last stay stable until m_valid&m_ready.
  - Words leave in issue order.
  - m_last=1 exactly on word len-1.
- Buffer never overflows; when full and not popping, no read is issued and mem_adr_r holds.
- done is asserted the cycle after the final (m_last) handshake. For len=0, done is asserted the cycle after start.
- start while busy is ignored; base_adr and len are not recaptured.
- RAM write traffic concurrent with reads is the writer's concern; this block reads whatever the RAM returns.
- m_data holds its last value when m_valid=0.

Test Plan:
- RAM preloaded r[i]=i+0x100; base=5, len=4, m_ready=1 -> m_valid in cycles 3..6 with data 0x105, 0x106, 0x107, 0x108; m_last only on 0x108; done pulse in cycle 7; busy low after.
- Same command with m_ready toggling 1,0,0,1,0,1... -> exactly 4 beats in order, no duplicates or drops, m_data stable during stalls, mem_adr_r never more than 2 ahead of the consumed words.
- base=62, len=4 (AWIDTH=6) -> mem_adr_r sequence 62, 63, 0, 1; data 0x13E, 0x13F, 0x100, 0x101.
- len=0 -> no m_valid, no reads, done=1 in cycle 1, busy stays 0.
- start re-pulsed with a different base mid-stream of a len=8 command -> the original 8 words only, single done.
- rst=1 for one cycle after word 2 of a len=8 command, m_ready=1 -> m_valid=0, busy=0, done=0 next cycle; a new command then streams from its own base with correct m_last.

Source files
------------

// File: rtl/dffram_stream_reader.sv
// Read-side streamer for the dual-port DFF RAM.
// Issues consecutive reads and emits the words on a valid/ready stream.
module dffram_stream_reader #(
    parameter int DWIDTH = 24,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_adr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_adr_r,
    input  logic [DWIDTH-1:0] mem_dat_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [AWIDTH-1:0] adr_q;
    logic [AWIDTH:0]   rem_q;
    logic              infl_q;
    logic              infl_last_q;

    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic              sp_vld_q, sp_vld_d;
    logic              sp_last_q, sp_last_d;
    logic [DWIDTH-1:0] sp_data_q, sp_data_d;

    logic       pop;
    logic [1:0] occ;
    logic       room;
    logic       accept;
    logic       issue;
    logic       final_issue;
    logic       drained;

    // Handshake and issue-slot arithmetic shared by FSM and datapath
    always_comb begin
        pop         = out_vld_q & m_ready;
        occ         = {1'b0, out_vld_q} + {1'b0, sp_vld_q};
        room        = ({1'b0, occ} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
        accept      = (state_q == S_IDLE) && start;
        issue       = (state_q == S_ISSUE) && room;
        final_issue = issue && (rem_q == {{AWIDTH{1'b0}}, 1'b1});
        drained     = !infl_q && (occ == {1'b0, pop});
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (final_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q == S_ISSUE) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // Command capture, read address and outstanding-read tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q       <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            if (accept) begin
                adr_q <= base_adr;
                rem_q <= len;
            end else if (issue) begin
                rem_q <= rem_q - 1'b1;
                if (!final_issue) begin
                    adr_q <= adr_q + 1'b1;
                end
            end
            infl_q      <= issue;
            infl_last_q <= final_issue;
        end
    end

    // Two-entry buffer: output register plus a spare slot for read latency
    always_comb begin
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        out_data_d = out_data_q;
        sp_vld_d   = sp_vld_q;
        sp_last_d  = sp_last_q;
        sp_data_d  = sp_data_q;
        if (!out_vld_q || pop) begin
            if (sp_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = sp_data_q;
                out_last_d = sp_last_q;
                sp_vld_d   = infl_q;
                if (infl_q) begin
                    sp_data_d = mem_dat_i;
                    sp_last_d = infl_last_q;
                end
            end else if (infl_q) begin
                out_vld_d  = 1'b1;
                out_data_d = mem_dat_i;
                out_last_d = infl_last_q;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (infl_q) begin
            sp_vld_d  = 1'b1;
            sp_data_d = mem_dat_i;
            sp_last_d = infl_last_q;
        end
    end

    // Buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_data_q <= '0;
            sp_vld_q   <= 1'b0;
            sp_last_q  <= 1'b0;
            sp_data_q  <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            out_data_q <= out_data_d;
            sp_vld_q   <= sp_vld_d;
            sp_last_q  <= sp_last_d;
            sp_data_q  <= sp_data_d;
        end
    end

    // Stream and RAM outputs
    always_comb begin
        mem_adr_r = adr_q;
        m_valid   = out_vld_q;
        m_data    = out_data_q;
        m_last    = out_last_q & out_vld_q;
    end

endmodule

// File: tb/tb_dffram_stream_reader.sv
// Randomized bench for dffram_stream_reader.
// Expected words come from a RAM array and a per-command queue.
module tb_dffram_stream_reader;

    localparam int DW = 24;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_adr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_adr_r;
    logic [DW-1:0] mem_dat_i;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    dffram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_adr (base_adr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_adr_r(mem_adr_r),
        .mem_dat_i(mem_dat_i),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [DEPTH];

    always @(posedge clk) mem_dat_i <= ram[mem_adr_r];

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    int    adr_log[$];

    int checks_n = 0;
    int errors_n = 0;
    int cyc = 0;
    int beats, done_cnt, done_cyc, last_cyc, first_vc, busy_cnt;
    int rmode = 0;
    int pidx = 0;
    logic [5:0] pat = 6'b101001;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    logic [DW-1:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks_n++;
        if (got !== want) begin
            errors_n++;
            $display("FAIL %s got %0h want %0h (cycle %0d)",
                     tag, got, want, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    m_ready = pat[pidx % 6];
                    pidx++;
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (rst) begin
            prev_stall = 1'b0;
            last_data  = '0;
            adr_log.delete();
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(stall_data));
                chk("hold_last", 32'(m_last), 32'(stall_last));
            end
            if (!m_valid) chk("idle_data", 32'(m_data), 32'(last_data));
            if (m_valid && first_vc < 0) first_vc = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    b = exp_q.pop_front();
                    chk("data", 32'(m_data), 32'(b.d));
                    chk("last", 32'(m_last), 32'(b.l));
                end
                beats++;
                if (m_last) last_cyc = cyc;
            end
            if (m_valid) last_data = m_data;
            prev_stall = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (busy) begin
                busy_cnt++;
                if (adr_log.size() == 0 || adr_log[$] != int'(mem_adr_r))
                    adr_log.push_back(int'(mem_adr_r));
                chk("ahead", 32'(adr_log.size() <= beats + 3), 32'd1);
            end
        end
    end

    task automatic prep(input int base, input int ln);
        exp_q.delete();
        adr_log.delete();
        for (int i = 0; i < ln; i++)
            exp_q.push_back('{ram[(base + i) % DEPTH], i == ln - 1});
        beats    = 0;
        done_cnt = 0;
        done_cyc = -1;
        last_cyc = -1;
        first_vc = -1;
        busy_cnt = 0;
    endtask

    task automatic run_cmd(input int base, input int ln, input int rm,
                           input bit repulse, input bit lat);
        int st;
        int n;
        rmode = rm;
        prep(base, ln);
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_adr = AW'(base);
        len      = (AW + 1)'(ln);
        st       = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
            if (repulse && k == 4) begin
                start    = 1'b1;
                base_adr = AW'(base + 17);
                len      = 7'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("beats", 32'(beats), 32'(ln));
        chk("pending", 32'(exp_q.size()), 32'd0);
        chk("done_cycle", 32'(done_cyc),
            32'(ln == 0 ? st + 1 : last_cyc + 1));
        chk("busy_after", 32'(busy), 32'd0);
        if (ln == 0) chk("busy_len0", 32'(busy_cnt), 32'd0);
        chk("adr_count", 32'(adr_log.size()), 32'(ln));
        n = adr_log.size() < ln ? adr_log.size() : ln;
        for (int i = 0; i < n; i++)
            chk("adr", 32'(adr_log[i]), 32'((base + i) % DEPTH));
        if (lat) begin
            chk("first_valid", 32'(first_vc), 32'(st + 3));
            chk("done_lat", 32'(done_cyc), 32'(st + ln + 3));
        end
    endtask

    task automatic reset_mid_cmd();
        int b0;
        int k;
        rmode = 0;
        prep(10, 8);
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_adr = 6'd10;
        len      = 7'd8;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (beats < 3 && k < 200) begin
            @(posedge clk);
            k++;
        end
        chk("pre_rst_beats", 32'(beats), 32'd3);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_adr", 32'(mem_adr_r), 32'd0);
        b0 = beats;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_beats", 32'(beats), 32'(b0));
        chk("rst_no_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        base_adr = '0;
        len      = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i + 'h100);
        prep(0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(m_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_last", 32'(m_last), 32'd0);
        chk("reset_data", 32'(m_data), 32'd0);
        chk("reset_adr", 32'(mem_adr_r), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_cmd(5, 4, 0, 1'b0, 1'b1);
        pidx = 0;
        run_cmd(5, 4, 2, 1'b0, 1'b0);
        run_cmd(62, 4, 0, 1'b0, 1'b1);
        run_cmd(9, 0, 0, 1'b0, 1'b0);
        run_cmd(20, 8, 0, 1'b1, 1'b0);
        run_cmd(30, 8, 1, 1'b1, 1'b0);
        reset_mid_cmd();
        run_cmd(40, 6, 1, 1'b0, 1'b0);
        run_cmd(3, 1, 0, 1'b0, 1'b1);

        for (int t = 0; t < 12; t++) begin
            int ln;
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            ln = (t == 5) ? 100 : (t == 8) ? 64 : int'($urandom_range(1, 20));
            run_cmd(int'($urandom_range(0, DEPTH - 1)), ln,
                    int'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end

endmodule
